multi_cycle_mips: RTL and testbench
===================================

Name: multi_cycle_mips

Overview:
- Multi-cycle successor to the team's single-cycle MIPS core. Uses the same instruction-port and data-memory-port naming.
- Each instruction runs through an FSM (FETCH, DECODE, EXEC, MEM, WB), so one ALU and one register file are shared across cycles.
- Data-memory access latency and data-memory address width are parametrised.
- A per-instruction retire strobe is provided for verification and cycle counting.

Parameters:
- ADDR_W, 7: data-memory word-address width; A = ALU byte address [ADDR_W+1:2].
- MEM_WAIT, 0: extra cycles MEM is held before load data is sampled. Range 0..15. MEM lasts MEM_WAIT+1 cycles.
- PC_RESET, 32'h0000_0000: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- IR_addr  out  32  instruction byte address; equals PC register.
- IR  in  32  instruction word; combinational from IR_addr, valid in the same cycle.
- ReadDataMem  in  32  data-memory read data.
- CEN  out  1  data-memory chip enable, active-low; CEN = WEN & OEN.
- WEN  out  1  data-memory write enable, active-low.
- OEN  out  1  data-memory output enable, active-low.
- A  out  ADDR_W  data-memory word address.
- Data2Mem  out  32  store data.
- retire  out  1  one-cycle pulse in the last cycle of every instruction.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=FETCH, PC=PC_RESET, all 32 GPRs=0, internal IR/MDR/ALUOut=0.
  - Outputs: WEN=OEN=CEN=1, A=0, Data2Mem=0, retire=0.
  - Reset mid-instruction aborts it: no register write, no retire, and WEN/OEN return high in the first cycle after the reset edge.
- Supported instructions: add, sub, and, or, slt, sll, srl, jr, addi, lw, sw, beq, bne, j, jal.
- Any other opcode/funct executes as a NOP in 3 cycles: FETCH, DECODE, EXEC with retire. There are no state changes other than PC+4.
- FETCH (1 cycle): latch IR; PC <= PC+4.
- DECODE (1 cycle):
  - Read rs and rt into A_reg and B_reg.
  - Sign-extend imm16. Branch target = PC + (sext(imm)<<2), computed from the already-incremented PC.
- EXEC (1 cycle):
  - R-type/addi: ALUOut <= result.
  - beq/bne: PC <= target if (rs==rt) xor bne; retire; next state FETCH.
  - j: PC <= {PC[31:28], addr26, 2'b00}; retire.
  - jal: same PC update as j, and $31 <= PC (return address = instruction address + 4); retire.
  - jr: PC <= rs value; retire.
  - lw/sw: ALUOut <= rs + sext(imm).
- MEM (MEM_WAIT+1 cycles, lw/sw only):
  - A = ALUOut[ADDR_W+1:2] and Data2Mem = B_reg, both stable for every MEM cycle.
  - lw: OEN=0 for all MEM cycles. MDR <= ReadDataMem at the edge ending the last MEM cycle. Then WB.
  - sw: WEN=0 only in the first MEM cycle; OEN=1. retire in the last MEM cycle. Then FETCH.
- WB (1 cycle): rd (R-type) or rt (addi/lw) <= ALUOut or MDR; retire.
- Register $0 always reads 0; writes to $0 are discarded.
- A register write at the WB edge is visible to the next instruction's DECODE.
- Outside MEM: WEN=OEN=CEN=1; A and Data2Mem hold their last value (0 after reset).
- Latency in cycles:
  - R-type and addi: 4.
  - lw: 5+MEM_WAIT.
  - sw: 4+MEM_WAIT.
  - beq, bne, j, jal, jr, NOP: 3.
- Arithmetic: 32-bit wrap-around with no overflow trap. slt is signed. sll/srl use shamt and operate on rt. A ignores the byte offset ALUOut[1:0].
- PC wraps modulo 2^32. Unaligned PC is not checked.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release -> IR_addr=0, CEN=WEN=OEN=1, A=0. First retire exactly 4 cycles after release for "addi $1,$0,5"; $1=5.
- R-type: "addi $2,$0,-3; sub $3,$1,$2; slt $4,$2,$1" -> $3=8, $4=1, retire pulses 4 cycles apart. "add $0,$1,$1" leaves $0=0.
- Memory, MEM_WAIT=2, ADDR_W=7:
  - "sw $1,8($0)" -> A=2, Data2Mem=5, WEN low exactly one cycle, CEN low 1 cycle, retire 6 cycles after FETCH start.
  - "lw $5,8($0)" with the model returning 5 -> OEN low 3 cycles, $5=5, 7 cycles total.
- Branch: beq $1,$1,+3 at PC=0x10 -> next IR_addr=0x20. bne $1,$1,+3 -> next IR_addr=0x14. Both take 3 cycles.
- Jump/link: jal 0x40 at PC=0x08 -> IR_addr=0x100, $31=0x0C. jr $31 -> IR_addr=0x0C.
- Reset during a sw's first MEM cycle -> WEN high in the following cycle, no retire, IR_addr=PC_RESET.

Source files
------------

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS core. Each instruction walks FETCH -> DECODE -> EXEC
// [-> MEM] [-> WB], so one ALU and one register file serve every step.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   IR_addr      instruction byte address (the PC register)
//   IR           instruction word, combinational from IR_addr
//   ReadDataMem  data-memory read data
//   CEN/WEN/OEN  data-memory chip/write/output enables, active-low
//   A            data-memory word address
//   Data2Mem     store data
//   retire       one-cycle pulse in the last cycle of every instruction
//
// Supported: add sub and or slt sll srl jr addi lw sw beq bne j jal.
// Anything else retires as a 3-cycle NOP (PC+4 only).
module multi_cycle_mips #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       IR_addr,
  input  logic [31:0]       IR,
  input  logic [31:0]       ReadDataMem,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       Data2Mem,
  output logic              retire
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2a;

  localparam logic [3:0] MemWaitC = 4'(MEM_WAIT);

  logic [2:0]        state_q, state_d;
  logic [31:0]       pc_q;
  logic [31:0]       ir_q;
  logic [31:0]       a_reg_q, b_reg_q;
  logic [31:0]       alu_out_q;
  logic [31:0]       mdr_q;
  logic [3:0]        mem_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rf_q [32];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  logic is_r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;

  always_comb begin
    is_r_alu = 1'b0;
    if (opcode == OpRtype) begin
      case (funct)
        FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnSrl: is_r_alu = 1'b1;
        default:                                        is_r_alu = 1'b0;
      endcase
    end
  end

  assign is_jr   = (opcode == OpRtype) && (funct == FnJr);
  assign is_addi = (opcode == OpAddi);
  assign is_lw   = (opcode == OpLw);
  assign is_sw   = (opcode == OpSw);
  assign is_beq  = (opcode == OpBeq);
  assign is_bne  = (opcode == OpBne);
  assign is_j    = (opcode == OpJ);
  assign is_jal  = (opcode == OpJal);

  logic writes_alu;  // instructions that finish with a register write of ALUOut
  logic is_mem;
  assign writes_alu = is_r_alu | is_addi;
  assign is_mem     = is_lw | is_sw;

  // Shared ALU: R-type uses B_reg, everything else rs + sext(imm)
  logic [31:0] alu_b, alu_res;
  assign alu_b = is_r_alu ? b_reg_q : imm_sext;

  always_comb begin
    alu_res = a_reg_q + alu_b;
    if (is_r_alu) begin
      case (funct)
        FnSub:   alu_res = a_reg_q - alu_b;
        FnAnd:   alu_res = a_reg_q & alu_b;
        FnOr:    alu_res = a_reg_q | alu_b;
        FnSlt:   alu_res = {31'd0, $signed(a_reg_q) < $signed(alu_b)};
        FnSll:   alu_res = b_reg_q << shamt;
        FnSrl:   alu_res = b_reg_q >> shamt;
        default: alu_res = a_reg_q + alu_b;
      endcase
    end
  end

  // pc_q already holds the incremented PC by the time EXEC runs
  logic [31:0] branch_target, jump_target;
  logic        take_branch;
  assign branch_target = pc_q + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign take_branch   = (a_reg_q == b_reg_q) ^ is_bne;

  logic mem_last;
  assign mem_last = (mem_cnt_q == MemWaitC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (writes_alu)  state_d = StWb;
        else if (is_mem) state_d = StMem;
        else             state_d = StFetch;
      end
      StMem: begin
        if (mem_last) state_d = is_lw ? StWb : StFetch;
      end
      StWb:     state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Single register-file write port: jal links in EXEC, others write in WB
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (state_q == StExec && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc_q;
    end else if (state_q == StWb) begin
      rf_we    = 1'b1;
      rf_waddr = is_r_alu ? rd : rt;
      rf_wdata = is_lw ? mdr_q : alu_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= PC_RESET;
      ir_q      <= 32'd0;
      a_reg_q   <= 32'd0;
      b_reg_q   <= 32'd0;
      alu_out_q <= 32'd0;
      mdr_q     <= 32'd0;
      mem_cnt_q <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StFetch: begin
          ir_q <= IR;
          pc_q <= pc_q + 32'd4;
        end
        StDecode: begin
          a_reg_q <= rf_q[rs];
          b_reg_q <= rf_q[rt];
        end
        StExec: begin
          alu_out_q <= alu_res;
          mem_cnt_q <= 4'd0;
          // Address and store data are registered here so they are stable
          // from the very first MEM cycle.
          if (is_mem) begin
            addr_q  <= alu_res[ADDR_W+1:2];
            wdata_q <= b_reg_q;
          end
          if ((is_beq || is_bne) && take_branch) pc_q <= branch_target;
          if (is_j || is_jal)                    pc_q <= jump_target;
          if (is_jr)                             pc_q <= a_reg_q;
        end
        StMem: begin
          if (mem_last) begin
            if (is_lw) mdr_q <= ReadDataMem;
          end else begin
            mem_cnt_q <= mem_cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
      // $0 is never written, so it always reads back as zero
      if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Store strobes only in the first MEM cycle; loads enable output throughout
  assign WEN      = !(state_q == StMem && is_sw && mem_cnt_q == 4'd0);
  assign OEN      = !(state_q == StMem && is_lw);
  assign CEN      = WEN & OEN;
  assign A        = addr_q;
  assign Data2Mem = wdata_q;
  assign IR_addr  = pc_q;

  assign retire = (state_q == StExec && !writes_alu && !is_mem) ||
                  (state_q == StMem && is_sw && mem_last) ||
                  (state_q == StWb);

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Bench for multi_cycle_mips (ADDR_W=7, MEM_WAIT=2). A small program runs from
// an instruction ROM; expected retire latencies / next PCs and expected store
// transactions are queued as the program is loaded and popped as the DUT
// produces them. Register contents are observed through stores.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_addr;
  logic [31:0] IR;
  logic [31:0] ReadDataMem;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic        retire;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    logic [31:0] next_pc;
  } ret_exp_t;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } st_exp_t;

  ret_exp_t ret_q[$];
  st_exp_t  st_q[$];

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:127];

  always #5 clk = ~clk;

  multi_cycle_mips #(
    .ADDR_W  (7),
    .MEM_WAIT(2),
    .PC_RESET(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR_addr    (IR_addr),
    .IR         (IR),
    .ReadDataMem(ReadDataMem),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .retire     (retire)
  );

  assign IR          = imem[IR_addr[9:2]];
  assign ReadDataMem = dmem[A];

  always @(posedge clk) begin
    if (WEN === 1'b0) dmem[A] <= Data2Mem;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int target);
    return {6'(op), 26'(target)};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] instr, input int lat,
                     input logic [31:0] next_pc);
    ret_exp_t r;
    imem[addr[9:2]] = instr;
    r.lat     = lat;
    r.next_pc = next_pc;
    ret_q.push_back(r);
  endtask

  // sw $rt, off($0) with the value rt is expected to hold
  task automatic put_sw(input logic [31:0] addr, input int rt, input int off,
                        input logic [31:0] exp_data);
    st_exp_t s;
    put(addr, enc_i(8'h2b, 0, rt, off), 6, addr + 32'd4);
    s.a = 7'(off >> 2);
    s.d = exp_data;
    st_q.push_back(s);
  endtask

  // Retire / memory-strobe monitor, sampled on the falling edge
  int          cyc_cnt = 0;
  int          wen_run = 0;
  int          oen_run = 0;
  logic        pc_pend = 1'b0;
  logic [31:0] pc_exp  = 32'd0;

  always @(negedge clk) begin
    ret_exp_t r;
    st_exp_t  s;
    if (pc_pend) begin
      check("next_pc", IR_addr, pc_exp);
      pc_pend = 1'b0;
    end
    if (rst_n !== 1'b1) begin
      cyc_cnt = 0;
    end else begin
      cyc_cnt++;
      check("cen", {31'd0, CEN}, {31'd0, WEN & OEN});
      if (retire === 1'b1) begin
        if (ret_q.size() == 0) begin
          check("spurious_retire", 32'd1, 32'd0);
        end else begin
          r = ret_q.pop_front();
          check("latency", cyc_cnt, r.lat);
          pc_exp  = r.next_pc;
          pc_pend = 1'b1;
        end
        cyc_cnt = 0;
      end
    end

    if (rst_n === 1'b1 && WEN === 1'b0) begin
      if (wen_run == 0) begin
        if (st_q.size() == 0) begin
          check("spurious_store", 32'd1, 32'd0);
        end else begin
          s = st_q.pop_front();
          check("store_addr", {25'd0, A}, {25'd0, s.a});
          check("store_data", Data2Mem, s.d);
          check("store_oen", {31'd0, OEN}, 32'd1);
        end
      end
      wen_run++;
    end else if (wen_run != 0) begin
      check("wen_width", wen_run, 1);
      wen_run = 0;
    end

    if (rst_n === 1'b1 && OEN === 1'b0) begin
      oen_run++;
    end else if (oen_run != 0) begin
      check("oen_width", oen_run, 3);
      oen_run = 0;
    end
  end

  task automatic wait_retires(input int budget);
    int i = 0;
    while (ret_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("retire_timeout", ret_q.size(), 0);
  endtask

  task automatic wait_wen_low(input int budget);
    int i = 0;
    while (WEN !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wen_seen", {31'd0, WEN}, 32'd0);
  endtask

  initial begin
    st_exp_t s;
    ret_exp_t r;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    for (int i = 0; i < 128; i++) dmem[i] = 32'd0;

    // Program, loaded in execution order
    put(32'h000, enc_i(8'h08, 0, 1, 5),          4, 32'h004);  // addi $1,$0,5
    put(32'h004, enc_i(8'h08, 0, 2, -3),         4, 32'h008);  // addi $2,$0,-3
    put(32'h008, enc_j(3, 26'h40),               3, 32'h100);  // jal 0x100
    put(32'h100, enc_r(1, 2, 3, 0, 8'h22),       4, 32'h104);  // sub $3,$1,$2
    put(32'h104, enc_r(2, 1, 4, 0, 8'h2a),       4, 32'h108);  // slt $4,$2,$1
    put(32'h108, enc_r(1, 1, 0, 0, 8'h20),       4, 32'h10C);  // add $0,$1,$1
    put_sw(32'h10C, 1, 8, 32'd5);                              // sw $1,8($0)
    put(32'h110, enc_i(8'h23, 0, 5, 8),          7, 32'h114);  // lw $5,8($0)
    put(32'h114, enc_r(0, 1, 6, 3, 8'h00),       4, 32'h118);  // sll $6,$1,3
    put(32'h118, enc_r(0, 2, 7, 28, 8'h02),      4, 32'h11C);  // srl $7,$2,28
    put(32'h11C, enc_r(1, 2, 8, 0, 8'h24),       4, 32'h120);  // and $8,$1,$2
    put(32'h120, enc_r(1, 2, 9, 0, 8'h25),       4, 32'h124);  // or $9,$1,$2
    put_sw(32'h124, 3, 12, 32'd8);
    put_sw(32'h128, 4, 16, 32'd1);
    put_sw(32'h12C, 0, 20, 32'd0);
    put_sw(32'h130, 5, 24, 32'd5);
    put_sw(32'h134, 31, 28, 32'h0000_000C);
    put_sw(32'h138, 6, 40, 32'd40);
    put_sw(32'h13C, 7, 44, 32'h0000_000F);
    put_sw(32'h140, 8, 48, 32'd5);
    put_sw(32'h144, 9, 52, 32'hFFFF_FFFD);
    put(32'h148, enc_r(31, 0, 0, 0, 8'h08),      3, 32'h00C);  // jr $31
    put(32'h00C, 32'hFC00_0000,                  3, 32'h010);  // unknown -> NOP
    put(32'h010, enc_i(8'h04, 1, 1, 3),          3, 32'h020);  // beq taken
    put(32'h020, enc_i(8'h05, 1, 1, 3),          3, 32'h024);  // bne not taken
    put(32'h024, enc_i(8'h05, 1, 2, 1),          3, 32'h02C);  // bne taken
    put_sw(32'h02C, 2, 32, 32'hFFFF_FFFD);
    // Store aborted by reset: its strobe is expected, its retire is not
    imem[12] = enc_i(8'h2b, 0, 1, 36);
    s.a = 7'd9;
    s.d = 32'd5;
    st_q.push_back(s);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ir_addr", IR_addr, 32'd0);
    check("rst_cen", {31'd0, CEN}, 32'd1);
    check("rst_wen", {31'd0, WEN}, 32'd1);
    check("rst_oen", {31'd0, OEN}, 32'd1);
    check("rst_a", {25'd0, A}, 32'd0);
    check("rst_d2m", Data2Mem, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);

    wait_retires(3000);
    wait_wen_low(100);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_wen", {31'd0, WEN}, 32'd1);
    check("abort_oen", {31'd0, OEN}, 32'd1);
    check("abort_retire", {31'd0, retire}, 32'd0);
    check("abort_ir_addr", IR_addr, 32'd0);
    check("abort_a", {25'd0, A}, 32'd0);
    check("abort_store_q", st_q.size(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    r.lat     = 4;
    r.next_pc = 32'h004;
    ret_q.push_back(r);
    wait_retires(100);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
